mux_bit_arbiter: RTL

- Shares one 32:1 bit-select unit (32-bit data x, 5-bit select y, 1-bit result f) among NREQ requesters.
- Each requester presents a data word and a bit index. A round-robin arbiter grants one requester at a time.
- The block drives the shared selector and captures its output. It returns the selected bit to the granted requester over a valid/ready response.
- Sits between the ALU-side clients and the single shared mux instance. The selector remains purely combinational outside this block.

---
 rtl/mux_bit_arbiter_if.sv | 28 ++
 rtl/mux_bit_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/mux_bit_arbiter_if.sv
// rtl/mux_bit_arbiter_if.sv - requester, response and shared-selector signals of the bit-select arbiter
interface mux_bit_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int SW   = 5
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ*SW-1:0] req_sel;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rsp_valid;
   logic               rsp_bit;
   logic [NREQ-1:0]    rsp_ready;
   logic [DW-1:0]      mux_x;
   logic [SW-1:0]      mux_y;
   logic               mux_f;
   logic               busy;

   modport slave (
      input  req, req_data, req_sel, rsp_ready, mux_f,
      output gnt, rsp_valid, rsp_bit, mux_x, mux_y, busy
   );

   modport master (
      output req, req_data, req_sel, rsp_ready, mux_f,
      input  gnt, rsp_valid, rsp_bit, mux_x, mux_y, busy
   );
endinterface

// File: rtl/mux_bit_arbiter.sv
// rtl/mux_bit_arbiter.sv - round-robin sharing of one 32:1 bit-select unit among NREQ requesters
module mux_bit_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int SW   = 5
) (
   input logic            clk,
   input logic            rst_n,
   mux_bit_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_win;
   logic [NREQ-1:0] r_rsp_valid;
   logic            r_rsp_bit;
   logic [DW-1:0]   r_mux_x;
   logic [SW-1:0]   r_mux_y;

   logic [PW-1:0]   w_win;
   logic            w_found;
   logic [NREQ-1:0] w_gnt;

   // First asserted request at or after the pointer, wrapping; only offered in IDLE.
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      if (r_state == IDLE) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req[(int'(r_ptr) + k) % NREQ]) begin
               w_found = 1'b1;
               w_win   = PW'((int'(r_ptr) + k) % NREQ);
            end
         end
      end
   end

   assign w_gnt = w_found ? (NREQ'(1) << w_win) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_win       <= '0;
         r_rsp_valid <= '0;
         r_rsp_bit   <= 1'b0;
         r_mux_x     <= '0;
         r_mux_y     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_mux_x <= bus.req_data[int'(w_win)*DW +: DW];
                  r_mux_y <= bus.req_sel[int'(w_win)*SW +: SW];
                  r_win   <= w_win;
                  r_state <= SAMPLE;
               end
            end
            SAMPLE: begin
               r_rsp_bit   <= bus.mux_f;
               r_rsp_valid <= NREQ'(1) << r_win;
               r_ptr       <= (int'(r_win) == NREQ - 1) ? '0 : r_win + PW'(1);
               r_state     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready[r_win]) begin
                  r_rsp_valid <= '0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = w_gnt;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_bit   = r_rsp_bit;
   assign bus.mux_x     = r_mux_x;
   assign bus.mux_y     = r_mux_y;
   assign bus.busy      = (r_state != IDLE);
endmodule
